// File: rtl/clock_select_sequencer_pkg.sv
// Shared types and default timing constants for the clock select sequencer.
package clksel_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ISSUE        = 3'd1,
        WAIT_ASSERT  = 3'd2,
        WAIT_RELEASE = 3'd3,
        HOLD         = 3'd4
    } state_t;

    localparam int unsigned DEF_TIMEOUT = 200;
    localparam int unsigned DEF_HOLDOFF = 16;

endpackage

// File: rtl/clock_select_sequencer_if.sv
// Request handshake, select-block control and status signals of the sequencer.
interface clock_select_sequencer_if;

    logic REQ_VALID;
    logic REQ_SEL;
    logic REQ_READY;
    logic SELECT;
    logic SELECT_ENABLE;
    logic FB_RST_N;
    logic CUR_SEL;
    logic BUSY;
    logic DONE;
    logic ERR;
    logic ERR_CLR;

    // Sequencer side.
    modport slave (
        input  REQ_VALID, REQ_SEL, FB_RST_N, ERR_CLR,
        output REQ_READY, SELECT, SELECT_ENABLE, CUR_SEL, BUSY, DONE, ERR
    );

    // System control / select block side.
    modport master (
        output REQ_VALID, REQ_SEL, FB_RST_N, ERR_CLR,
        input  REQ_READY, SELECT, SELECT_ENABLE, CUR_SEL, BUSY, DONE, ERR
    );

endinterface

// File: rtl/clock_select_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clock_select_sequencer.sv
// Sequences clock-switch requests into the two-clock select block and
// confirms completion by watching the block's output reset.
module clock_select_sequencer
    import clksel_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned HOLDOFF     = DEF_HOLDOFF
) (
    input  logic                     CLK,
    input  logic                     RST,
    clock_select_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HO_LAST  = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_select;
    logic             r_cur_sel;
    logic             r_done;
    logic             r_err;
    logic             w_fb_s;
    logic             w_ready;
    logic             w_accept;
    logic             w_done_next;
    logic             w_err_set;
    logic             w_cur_load;
    logic             w_select_load;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_fb_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (bus.FB_RST_N),
        .o_q   (w_fb_s)
    );

    // Ready is masked by RST so no request is seen while reset is applied.
    assign w_ready  = (r_state == IDLE) && !RST;
    assign w_accept = bus.REQ_VALID && w_ready;

    // Next-state, counter and event decode for the switch sequence.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        w_done_next   = 1'b0;
        w_err_set     = 1'b0;
        w_cur_load    = 1'b0;
        w_select_load = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_accept) begin
                    if (bus.REQ_SEL == r_cur_sel) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_select_load = 1'b1;
                        w_state_next  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_cnt_next   = '0;
                w_state_next = WAIT_ASSERT;
            end
            WAIT_ASSERT: begin
                if (!w_fb_s) begin
                    w_cnt_next   = '0;
                    w_state_next = WAIT_RELEASE;
                end else if (r_cnt >= TO_LAST) begin
                    w_err_set    = 1'b1;
                    w_done_next  = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = HOLD;
                end
            end
            WAIT_RELEASE: begin
                // The mux has already switched here, so a timeout still commits.
                if (w_fb_s || (r_cnt >= TO_LAST)) begin
                    w_err_set    = !w_fb_s;
                    w_cur_load   = 1'b1;
                    w_done_next  = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (r_cnt >= HO_LAST) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    // State register plus counter, selection and status flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_select  <= 1'b0;
            r_cur_sel <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            if (w_select_load) begin
                r_select <= bus.REQ_SEL;
            end
            if (w_cur_load) begin
                r_cur_sel <= r_select;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (bus.ERR_CLR) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.REQ_READY     = w_ready;
    assign bus.SELECT        = r_select;
    assign bus.SELECT_ENABLE = (r_state == ISSUE);
    assign bus.CUR_SEL       = r_cur_sel;
    assign bus.BUSY          = (r_state != IDLE);
    assign bus.DONE          = r_done;
    assign bus.ERR           = r_err;

endmodule

// File: tb/tb_clock_select_sequencer.sv
// Directed self-checking bench for clock_select_sequencer.
module tb_clock_select_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    clock_select_sequencer_if bus();

    clock_select_sequencer #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .TIMEOUT    (200),
        .HOLDOFF    (16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_SEL   = 1'b0;
        bus.FB_RST_N  = 1'b1;
        bus.ERR_CLR   = 1'b0;
        rst           = 1'b1;
        step();
        step();

        // Reset values.
        check_eq("rst_ready", bus.REQ_READY, 0);
        check_eq("rst_select", bus.SELECT, 0);
        check_eq("rst_se", bus.SELECT_ENABLE, 0);
        check_eq("rst_cur", bus.CUR_SEL, 0);
        check_eq("rst_busy", bus.BUSY, 0);
        check_eq("rst_done", bus.DONE, 0);
        check_eq("rst_err", bus.ERR, 0);
        rst = 1'b0;
        step();
        check_eq("ready_after_rst", bus.REQ_READY, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("idle_se", bus.SELECT_ENABLE, 0);
        end

        // Same-selection request: immediate DONE, no switch.
        bus.REQ_VALID = 1'b1;
        bus.REQ_SEL   = 1'b0;
        step();
        check_eq("nsw_done", bus.DONE, 1);
        check_eq("nsw_se", bus.SELECT_ENABLE, 0);
        check_eq("nsw_busy", bus.BUSY, 0);
        bus.REQ_VALID = 1'b0;
        step();
        check_eq("nsw_done_end", bus.DONE, 0);
        check_eq("nsw_busy2", bus.BUSY, 0);

        // Normal switch to A_CLK; feedback low at T+3, high at T+8.
        bus.REQ_VALID = 1'b1;
        bus.REQ_SEL   = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            step();
            check_eq("sw_se", bus.SELECT_ENABLE, (k == 1));
            check_eq("sw_done", bus.DONE, (k == 11));
            check_eq("sw_cur", bus.CUR_SEL, (k >= 11));
            check_eq("sw_ready", bus.REQ_READY, (k >= 27));
            check_eq("sw_busy", bus.BUSY, (k < 27));
            check_eq("sw_select", bus.SELECT, 1);
            if (k == 1) bus.REQ_VALID = 1'b0;
            if (k == 3) bus.FB_RST_N = 1'b0;
            if (k == 8) bus.FB_RST_N = 1'b1;
        end

        // Reset during WAIT_RELEASE of a switch back to B_CLK.
        bus.REQ_VALID = 1'b1;
        bus.REQ_SEL   = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) begin
                check_eq("rr_se", bus.SELECT_ENABLE, 1);
                bus.REQ_VALID = 1'b0;
            end
            if (k == 3) bus.FB_RST_N = 1'b0;
        end
        check_eq("rr_busy_pre", bus.BUSY, 1);
        check_eq("rr_cur_pre", bus.CUR_SEL, 1);
        rst = 1'b1;
        step();
        check_eq("rr_cur", bus.CUR_SEL, 0);
        check_eq("rr_select", bus.SELECT, 0);
        check_eq("rr_busy", bus.BUSY, 0);
        check_eq("rr_done", bus.DONE, 0);
        check_eq("rr_se", bus.SELECT_ENABLE, 0);
        bus.FB_RST_N = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_eq("rr_ready", bus.REQ_READY, 1);
        step();
        step();
        step();

        // Switch with feedback stuck high: WAIT_ASSERT timeout.
        bus.REQ_VALID = 1'b1;
        bus.REQ_SEL   = 1'b1;
        for (int k = 1; k <= 218; k++) begin
            step();
            check_eq("to_done", bus.DONE, (k == 202));
            check_eq("to_err", bus.ERR, (k >= 202));
            check_eq("to_cur", bus.CUR_SEL, 0);
            check_eq("to_ready", bus.REQ_READY, (k == 218));
            if (k == 1) bus.REQ_VALID = 1'b0;
        end
        step();
        step();
        check_eq("err_sticky", bus.ERR, 1);
        bus.ERR_CLR = 1'b1;
        step();
        check_eq("err_clr", bus.ERR, 0);
        bus.ERR_CLR = 1'b0;
        step();

        // Request held valid across a whole switch: second accept after HOLD.
        bus.REQ_VALID = 1'b1;
        bus.REQ_SEL   = 1'b1;
        check_eq("hv_ready0", bus.REQ_READY, 1);
        for (int k = 1; k <= 28; k++) begin
            step();
            check_eq("hv_ready", bus.REQ_READY, (k >= 27));
            check_eq("hv_done", bus.DONE, (k == 11 || k == 28));
            check_eq("hv_se", bus.SELECT_ENABLE, (k == 1));
            check_eq("hv_busy", bus.BUSY, (k <= 26));
            check_eq("hv_cur", bus.CUR_SEL, (k >= 11));
            if (k == 3) bus.FB_RST_N = 1'b0;
            if (k == 8) bus.FB_RST_N = 1'b1;
            if (k == 28) bus.REQ_VALID = 1'b0;
        end
        step();
        check_eq("hv_done_end", bus.DONE, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_select_sequencer.md
Name: clock_select_sequencer

Overview:
- Control stage directly upstream of the ungated two-clock select block.
- Accepts clock-switch requests over a valid/ready handshake and drives that block's SELECT/SELECT_ENABLE.
- Watches the select block's output reset (OUT_RST_N) through a synchronizer to confirm that the switch completed, and enforces a minimum hold-off between switches.
- Reports completion, the current selection and timeout errors to system control logic; runs on the same CLK as the select block's control side.

Parameters:
- SYNC_STAGES, 2: flop depth of the synchronizer on OUT_RST_N feedback; legal range ≥2.
- CNT_W, 8: width of the shared timeout/hold-off counter.
- TIMEOUT, 200: cycles allowed for each feedback phase (assert, then release) before error; must be < 2^CNT_W.
- HOLDOFF, 16: idle cycles enforced after a completed or failed switch before the next request is accepted; legal range ≥1.

Ports:
- CLK  in  1  control clock; same clock as the select block's CLK.
- RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  1  switch request valid.
- REQ_SEL  in  1  requested selection: 1 = A_CLK, 0 = B_CLK.
- REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY.
- SELECT  out  1  to select block SELECT.
- SELECT_ENABLE  out  1  to select block SELECT_ENABLE; single-cycle pulse.
- FB_RST_N  in  1  select block OUT_RST_N; asynchronous to CLK.
- CUR_SEL  out  1  last committed selection.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle pulse when a request finishes, with or without error.
- ERR  out  1  sticky timeout flag.
- ERR_CLR  in  1  clears ERR.

Behaviour:
- All flops reset synchronously on RST=1.
  - Outputs during/after reset: SELECT=0, SELECT_ENABLE=0, CUR_SEL=0 (matches the select block's reset choice of B_CLK), REQ_READY=0 while RST=1, then 1 from the first cycle after RST falls, BUSY=0, DONE=0, ERR=0.
  - Counter and synchronizer flops reset to 0, so the synced feedback reads "in reset" until real samples propagate.
- FB_RST_N passes through SYNC_STAGES flops to give fb_s; only fb_s is used.
- States: IDLE, ISSUE, WAIT_ASSERT, WAIT_RELEASE, HOLD.
- IDLE:
  - REQ_READY=1.
  - Accept at cycle T with REQ_SEL == CUR_SEL: no switch; DONE=1 at T+1; stay in IDLE.
  - Accept at cycle T with REQ_SEL != CUR_SEL: latch REQ_SEL; go to ISSUE.
- ISSUE, one cycle (T+1):
  - SELECT_ENABLE=1 and SELECT=latched value.
  - SELECT holds the latched value from then on.
  - Counter cleared; go to WAIT_ASSERT.
- WAIT_ASSERT:
  - Wait for fb_s == 0, meaning the select block has seen the change and asserted its reset.
  - Counter increments every cycle.
  - On counter == TIMEOUT-1 without fb_s == 0: ERR=1, DONE pulse, go to HOLD. CUR_SEL is not updated.
- WAIT_RELEASE:
  - Counter cleared on entry.
  - Wait for fb_s == 1.
  - Then CUR_SEL <= SELECT, DONE pulse, go to HOLD.
  - Timeout works as in WAIT_ASSERT, except CUR_SEL <= SELECT anyway, because the mux has switched.
- HOLD:
  - Counter cleared on entry.
  - Stay HOLDOFF cycles with REQ_READY=0, then go to IDLE.
- REQ_READY is 0 in every state except IDLE; requests during BUSY stall and are not dropped.
- Simultaneous events:
  - ERR_CLR with a same-cycle timeout: set wins.
  - RST overrides everything.
- Reset mid-operation (any state): return to IDLE with CUR_SEL=0. A pending switch is abandoned; the select block is reset by its own RST_N.
- SELECT_ENABLE is never high for more than one cycle and never high outside ISSUE.
- Counter comparisons are unsigned at width CNT_W; the counter saturates and never wraps.

Decomposition:
- Shared package clksel_pkg:
  - state enum (IDLE=0, ISSUE=1, WAIT_ASSERT=2, WAIT_RELEASE=3, HOLD=4), 3-bit encoding;
  - default TIMEOUT and HOLDOFF constants.
- One sub-module: sync_bit, a parameterized SYNC_STAGES-deep synchronizer with synchronous reset value 0.

Test Plan:
- Reset, then hold FB_RST_N=1 -> REQ_READY=1 one cycle after RST falls; CUR_SEL=0; SELECT_ENABLE never pulses.
- Request REQ_SEL=1 accepted at T; model drops FB_RST_N at T+3 and raises it at T+8 -> SELECT_ENABLE=1 only at T+1 with SELECT=1; DONE at the cycle fb_s rises +1; CUR_SEL=1; REQ_READY=0 for the following 16 cycles.
- Request REQ_SEL=0 while CUR_SEL=0 -> DONE at T+1, no SELECT_ENABLE, BUSY stays 0.
- Request REQ_SEL=1 with FB_RST_N held at 1 -> ERR=1 and DONE exactly 200 cycles after entering WAIT_ASSERT; CUR_SEL stays 0; ERR stays set until ERR_CLR.
- Assert RST during WAIT_RELEASE -> next cycle: state IDLE, CUR_SEL=0, SELECT=0, BUSY=0, no DONE pulse.
- Hold REQ_VALID high continuously during a switch -> the second request is accepted exactly in the first IDLE cycle after HOLD, not earlier.
